// File: rtl/ofm_drain_if.sv
// rtl/ofm_drain_if.sv - output-buffer read port and result-lane stream bundle
//
// Purpose : groups the output-buffer read port (mem_*) and the 16-bit result
//           stream (out_*) between ofm_drain and its neighbours.
// Signals : mem_ena/mem_addr   drain -> buffer, read request
//           mem_dout           buffer -> drain, data one cycle after mem_ena
//           out_data/out_valid/out_last  drain -> sink
//           out_ready          sink -> drain
// Modports: master = drain side, slave = buffer/sink side.
interface ofm_drain_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 64
);
    logic              mem_ena;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_dout;
    logic [15:0]       out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;

    modport master (
        output mem_ena, mem_addr, out_data, out_valid, out_last,
        input  mem_dout, out_ready
    );

    modport slave (
        input  mem_ena, mem_addr, out_data, out_valid, out_last,
        output mem_dout, out_ready
    );
endinterface

// File: rtl/ofm_drain.sv
// rtl/ofm_drain.sv - drains 64-bit output-buffer words as four 16-bit lanes
//
// Purpose : on start, reads word_count words from base_addr upward (address
//           wraps modulo 2^ADDR_W) and streams each word MSB lane first.
// Ports   : clk, rst_n (sync, active-low)
//           start, base_addr, word_count   drain request, sampled in IDLE
//           bus (ofm_drain_if.master)      buffer read port + result stream
//           busy                            high outside IDLE
//           done                            one-cycle completion pulse
module ofm_drain #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] word_count,
    ofm_drain_if.master       bus,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_SEND,
        S_DONE
    } state_t;

    state_t            state_q;
    state_t            state_d;

    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W-1:0] count_q;
    logic [ADDR_W-1:0] index_q;
    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        lane_q;
    logic [DATA_W-1:0] word_q;

    logic              xfer;
    logic              last_word;

    assign xfer      = (state_q == S_SEND) && bus.out_ready;
    assign last_word = (index_q == count_q - ADDR_W'(1));

    // Address register is loaded on entry to READ so it already holds
    // base+index during READ and keeps its value everywhere else.
    assign bus.mem_addr = addr_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = (word_count != '0) ? S_READ : S_DONE;
                end
            end
            S_READ: state_d = S_WAIT;
            S_WAIT: state_d = S_SEND;
            S_SEND: begin
                if (xfer && (lane_q == 2'd3)) begin
                    state_d = last_word ? S_DONE : S_READ;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy          = (state_q != S_IDLE);
        done          = (state_q == S_DONE);
        bus.mem_ena   = (state_q == S_READ);
        bus.out_valid = 1'b0;
        bus.out_last  = 1'b0;
        bus.out_data  = 16'h0000;
        if (state_q == S_SEND) begin
            bus.out_valid = 1'b1;
            bus.out_last  = (lane_q == 2'd3) && last_word;
            case (lane_q)
                2'd0:    bus.out_data = word_q[63:48];
                2'd1:    bus.out_data = word_q[47:32];
                2'd2:    bus.out_data = word_q[31:16];
                default: bus.out_data = word_q[15:0];
            endcase
        end
    end

    // Request fields are only written from IDLE, so a start arriving while
    // busy cannot disturb a drain in progress.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            base_q  <= '0;
            count_q <= '0;
            index_q <= '0;
            addr_q  <= '0;
            lane_q  <= '0;
            word_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start && (word_count != '0)) begin
                        base_q  <= base_addr;
                        count_q <= word_count;
                        index_q <= '0;
                        addr_q  <= base_addr;
                    end
                end
                S_WAIT: begin
                    word_q <= bus.mem_dout;
                    lane_q <= 2'd0;
                end
                S_SEND: begin
                    if (xfer) begin
                        if (lane_q != 2'd3) begin
                            lane_q <= lane_q + 2'd1;
                        end else if (!last_word) begin
                            index_q <= index_q + ADDR_W'(1);
                            addr_q  <= base_q + index_q + ADDR_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ofm_drain.sv
// tb/tb_ofm_drain.sv - scoreboard bench for ofm_drain
module tb_ofm_drain;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] base_addr;
    logic [15:0] word_count;
    logic        busy;
    logic        done;

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;

    logic [15:0] addr_q[$];
    logic [16:0] lane_q[$];   // {last, data}
    logic [63:0] mem [logic [15:0]];

    ofm_drain_if #(.ADDR_W(16), .DATA_W(64)) bus ();

    ofm_drain #(.ADDR_W(16), .DATA_W(64)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .base_addr  (base_addr),
        .word_count (word_count),
        .bus        (bus.master),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] mem_rd(input logic [15:0] a);
        if (mem.exists(a)) return mem[a];
        return {a, a ^ 16'hffff, a + 16'h1111, 16'h5a5a};
    endfunction

    always @(posedge clk) begin
        if (bus.mem_ena) bus.mem_dout <= mem_rd(bus.mem_addr);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (bus.mem_ena) begin
                if (addr_q.size() == 0) check("unexp_read", 1, 0);
                else check("rd_addr", bus.mem_addr, addr_q.pop_front());
            end
            if (bus.out_valid && bus.out_ready) begin
                if (lane_q.size() == 0) check("unexp_xfer", 1, 0);
                else check("lane", {bus.out_last, bus.out_data}, lane_q.pop_front());
            end
            if (done) done_cnt++;
        end
    end

    task automatic expect_drain(input logic [15:0] base, input int count);
        for (int w = 0; w < count; w++) begin
            logic [15:0] a;
            logic [63:0] d;
            a = base + 16'(w);
            d = mem_rd(a);
            addr_q.push_back(a);
            for (int l = 0; l < 4; l++) begin
                lane_q.push_back({(w == count - 1) && (l == 3), d[63 - 16*l -: 16]});
            end
        end
    endtask

    // Returns one cycle after start was sampled (i.e. in cycle t+1).
    task automatic start_pulse(input logic [15:0] base, input logic [15:0] count);
        @(posedge clk); #1;
        start = 1'b1; base_addr = base; word_count = count;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done();
        bit seen = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (done) begin seen = 1; break; end
        end
        check("done_seen", seen, 1);
    endtask

    initial begin
        int dc;
        logic [15:0] exp34 [4];
        exp34[0] = 16'h0001; exp34[1] = 16'h0002; exp34[2] = 16'h0003; exp34[3] = 16'h0004;
        rst_n = 1'b0; start = 1'b0; base_addr = '0; word_count = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ena", bus.mem_ena, 0);
        check("rst_addr", bus.mem_addr, 0);
        check("rst_valid", bus.out_valid, 0);
        check("rst_last", bus.out_last, 0);
        check("rst_data", bus.out_data, 0);

        // single word, exact cycle timing
        mem[16'h0000] = 64'h0001_0002_0003_0004;
        dc = done_cnt;
        expect_drain(16'h0000, 1);
        start_pulse(16'h0000, 16'd1);
        @(negedge clk);
        check("t1_ena", bus.mem_ena, 1);
        check("t1_addr", bus.mem_addr, 0);
        @(negedge clk);
        check("t2_ena", bus.mem_ena, 0);
        check("t2_valid", bus.out_valid, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t3_valid", bus.out_valid, 1);
            check("t3_data", bus.out_data, exp34[i]);
            check("t3_last", bus.out_last, i == 3);
        end
        @(negedge clk);
        check("t7_done", done, 1);
        check("t7_valid", bus.out_valid, 0);
        @(negedge clk);
        check("t8_busy", busy, 0);
        @(posedge clk);
        check("t34_donecnt", done_cnt - dc, 1);

        // backpressure on lane 2
        expect_drain(16'h0000, 1);
        start_pulse(16'h0000, 16'd1);
        repeat (4) @(posedge clk);
        #1 bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_data", bus.out_data, 16'h0003);
            check("stall_valid", bus.out_valid, 1);
            check("stall_ena", bus.mem_ena, 0);
        end
        @(posedge clk); #1 bus.out_ready = 1'b1;
        @(negedge clk);
        check("rel_data", bus.out_data, 16'h0003);
        @(negedge clk);
        check("next_data", bus.out_data, 16'h0004);
        check("next_last", bus.out_last, 1);
        wait_done();

        // zero count
        @(posedge clk);
        dc = done_cnt;
        start_pulse(16'h1234, 16'd0);
        @(negedge clk);
        check("z_done", done, 1);
        check("z_busy", busy, 1);
        @(negedge clk);
        check("z_done2", done, 0);
        check("z_busy2", busy, 0);
        @(posedge clk);
        check("z_donecnt", done_cnt - dc, 1);

        // address wrap
        mem[16'hffff] = 64'haaaa_bbbb_cccc_dddd;
        mem[16'h0000] = 64'h1111_2222_3333_4444;
        expect_drain(16'hffff, 2);
        start_pulse(16'hffff, 16'd2);
        wait_done();
        @(posedge clk);
        check("wrap_empty", addr_q.size() + lane_q.size(), 0);

        // reset mid-drain
        dc = done_cnt;
        expect_drain(16'h0100, 3);
        start_pulse(16'h0100, 16'd3);
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        check("mr_valid", bus.out_valid, 0);
        check("mr_busy", busy, 0);
        addr_q.delete();
        lane_q.delete();
        repeat (5) @(posedge clk);
        check("mr_nodone", done_cnt - dc, 0);
        expect_drain(16'h0010, 1);
        start_pulse(16'h0010, 16'd1);
        wait_done();
        @(posedge clk);
        check("mr_restart", done_cnt - dc, 1);

        // start coincident with reset
        @(posedge clk); #1;
        rst_n = 1'b0; start = 1'b1; base_addr = 16'h0200; word_count = 16'd1;
        @(posedge clk); #1;
        rst_n = 1'b1; start = 1'b0;
        @(negedge clk);
        check("rs_busy", busy, 0);
        repeat (8) @(posedge clk);

        // second start during SEND is ignored
        dc = done_cnt;
        expect_drain(16'h0020, 2);
        start_pulse(16'h0020, 16'd2);
        repeat (3) @(posedge clk);
        #1 start = 1'b1; base_addr = 16'h0040; word_count = 16'd5;
        @(posedge clk); #1 start = 1'b0;
        wait_done();
        repeat (10) @(posedge clk);
        check("ign_donecnt", done_cnt - dc, 1);
        check("ign_busy", busy, 0);
        check("sb_empty", addr_q.size() + lane_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ofm_drain.md
OFM_DRAIN -- requirements
Module: ofm_drain

Interface
REQ-001 Parameter ADDR_W, default 16, width of output-buffer address and base/count inputs.
REQ-002 Parameter DATA_W, default 64, width of output-buffer read word; fixed at four 16-bit lanes.
REQ-003 clk  input  1  single clock, rising edge; one clock, reset is synchronous and active-low.
REQ-004 rst_n  input  1  synchronous active-low reset.
REQ-005 start  input  1  one-cycle pulse (layer_ready) requesting drain of output buffer.
REQ-006 base_addr  input  ADDR_W  first output-buffer word address, sampled on accepted start.
REQ-007 word_count  input  ADDR_W  number of 64-bit words to drain, sampled on accepted start.
REQ-008 mem_ena  output  1  output-buffer port enable (read only; block never writes).
REQ-009 mem_addr  output  ADDR_W  output-buffer read address.
REQ-010 mem_dout  input  DATA_W  output-buffer read data, valid the cycle after mem_ena=1.
REQ-011 out_data  output  16  result lane being offered.
REQ-012 out_valid  output  1  out_data valid.
REQ-013 out_ready  input  1  downstream accepts; transfer when out_valid & out_ready.
REQ-014 out_last  output  1  high with final lane of final word.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 done  output  1  one-cycle pulse on drain completion.

Function
REQ-017 FSM states IDLE, READ, WAIT, SEND, DONE; encoding free.
REQ-018 IDLE: start=1 and word_count!=0 -> READ, latch base_addr, word_count, index=0; start=1 and word_count=0 -> DONE; else stay.
REQ-019 start while busy=1 is ignored, with no effect on latched values.
REQ-020 READ (exactly one cycle): mem_ena=1, mem_addr=base+index mod 2^ADDR_W -> WAIT.
REQ-021 WAIT (exactly one cycle): mem_ena=0; capture mem_dout into word register, lane=0 -> SEND.
REQ-022 SEND: out_valid=1; lane 0..3 selects [63:48],[47:32],[31:16],[15:0] respectively.
REQ-023 SEND: out_data and out_last stay stable while out_valid & !out_ready; no memory access during SEND.
REQ-024 Transfer on lane<3: lane+1, stay in SEND.
REQ-025 Transfer on lane 3: index+1==count -> DONE; else index+1 and -> READ.
REQ-026 out_last=1 only in SEND with lane=3 and index=count-1.
REQ-027 DONE (exactly one cycle): done=1, busy=1 -> IDLE.
REQ-028 Latency: start in cycle t -> READ t+1, first out_valid t+3; with out_ready held high each word takes 6 cycles (1 READ + 1 WAIT + 4 SEND).
REQ-029 Address wrap: base+index computed modulo 2^ADDR_W; 0xFFFF followed by 0x0000 is legal.
REQ-030 Outside SEND: out_valid=0, out_last=0, out_data=0; outside READ: mem_ena=0; mem_addr holds last value.

Reset
REQ-031 rst_n=0 at a clock edge -> next cycle state IDLE, all outputs 0, index/lane/word register cleared.
REQ-032 Reset mid-drain abandons the transfer without a done pulse; a later start restarts from the newly sampled base_addr.
REQ-033 start coincident with rst_n=0 is ignored.

Verification
REQ-034 mem[0x0000]=0x0001_0002_0003_0004, base=0, count=1, out_ready=1, start at t -> mem_ena t+1 addr 0; out_data 0x0001..0x0004 at t+3..t+6; out_last at t+6 only; done at t+7; busy low t+8.
REQ-035 Same data, out_ready low for 5 cycles while lane 2 offered -> out_data held 0x0003, out_valid=1, mem_ena=0 throughout; 0x0004 follows one cycle after out_ready rises.
REQ-036 count=0, start at t -> done at t+1, busy high t+1 only, no mem_ena, no out_valid.
REQ-037 base=0xFFFF, count=2, mem[0xFFFF]=0xAAAA_BBBB_CCCC_DDDD, mem[0x0000]=0x1111_2222_3333_4444 -> reads 0xFFFF then 0x0000; eight lanes in order; out_last on 0x4444 only.
REQ-038 rst_n low one cycle after second lane of a 3-word drain -> out_valid=0, busy=0, no done; new start with base=0x0010, count=1 -> reads 0x0010.
REQ-039 Second start pulse during SEND of a 2-word drain -> ignored; exactly 8 transfers and one done pulse.
